// File: rtl/display_sink_if.sv
// Downstream word port of display_sink.
// Handshake: a word transfers on a rising clock edge where out_valid and out_ready are both 1;
// out_valid never waits on out_ready, and out_data is stable while out_valid is high and not yet accepted.
interface display_sink_if;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/display_sink.sv
// Captures processor display words on each rising display strobe into a small FIFO,
// scans the latest word onto a 4-digit multiplexed hex display and reports completion.
module display_sink #(
    parameter int DEPTH    = 4,
    parameter int SCAN_DIV = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   display_availiable,
    input  logic [15:0]            value,
    input  logic                   done,
    display_sink_if.master         sink,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [15:0]            last_value,
    output logic [3:0]             digit_an,
    output logic [3:0]             digit_hex,
    output logic                   finished
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [AW:0]   FULL      = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          da_q;
    logic          done_seen;
    logic [SW-1:0] scan_cnt;
    logic [1:0]    digit_idx;

    logic          capture;
    logic          pop;
    logic          push;
    logic [AW:0]   count_next;
    logic          done_seen_next;

    assign sink.out_valid = (count != '0);
    assign sink.out_data  = mem[rd_ptr];

    // A full FIFO still accepts a word when the head leaves on the same edge.
    always_comb begin
        capture        = display_availiable & ~da_q;
        pop            = sink.out_valid & sink.out_ready;
        push           = capture & ((count != FULL) | pop);
        count_next     = count;
        done_seen_next = done_seen | done;
        if (push && !pop) begin
            count_next = count + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            da_q       <= 1'b0;
            overflow   <= 1'b0;
            last_value <= '0;
            done_seen  <= 1'b0;
            finished   <= 1'b0;
        end else begin
            da_q      <= display_availiable;
            count     <= count_next;
            done_seen <= done_seen_next;
            finished  <= finished | (done_seen_next & (count_next == '0));
            if (capture) begin
                last_value <= value;
            end
            if (capture && !push) begin
                overflow <= 1'b1;
            end
            if (push) begin
                mem[wr_ptr] <= value;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

    assign digit_an  = ~(4'b0001 << digit_idx);
    assign digit_hex = last_value[{digit_idx, 2'b00} +: 4];
endmodule

// File: tb/tb_display_sink.sv
// Bench for display_sink: directed scenarios plus random traffic, with a queue-based
// reference model and a monitor that compares every cycle on the falling edge.
module tb_display_sink;
  localparam int DEPTH    = 4;
  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic        da;
  logic [15:0] value;
  logic        done;
  logic [2:0]  count;
  logic        overflow;
  logic [15:0] last_value;
  logic [3:0]  digit_an;
  logic [3:0]  digit_hex;
  logic        finished;

  display_sink_if sink_if ();

  display_sink #(.DEPTH(DEPTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .display_availiable (da),
    .value              (value),
    .done               (done),
    .sink               (sink_if.master),
    .count              (count),
    .overflow           (overflow),
    .last_value         (last_value),
    .digit_an           (digit_an),
    .digit_hex          (digit_hex),
    .finished           (finished)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  int edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: committed state (after last edge) and pending state (after next edge)
  logic [15:0] exp_q[$];
  int m_size, m_last, m_ovf, m_done, m_fin;
  int p_size, p_last, p_ovf, p_done, p_fin;
  bit last_da;

  task automatic model_reset();
    exp_q.delete();
    m_size = 0; m_last = 0; m_ovf = 0; m_done = 0; m_fin = 0;
    p_size = 0; p_last = 0; p_ovf = 0; p_done = 0; p_fin = 0;
    last_da = 1'b0;
  endtask

  // driver: one clock per call; inputs change 1 time unit after the rising edge
  task automatic step(input bit d, input logic [15:0] v, input bit rdy, input bit dn);
    bit cap, pp, psh;
    @(posedge clk);
    #1;
    m_size = p_size; m_last = p_last; m_ovf = p_ovf; m_done = p_done; m_fin = p_fin;
    da = d; value = v; sink_if.out_ready = rdy; done = dn;
    cap = d && !last_da;
    last_da = d;
    pp  = (m_size > 0) && rdy;
    psh = cap && ((m_size < DEPTH) || pp);
    p_size = m_size + (psh ? 1 : 0) - (pp ? 1 : 0);
    p_last = cap ? int'(v) : m_last;
    p_ovf  = (cap && !psh) ? 1 : m_ovf;
    p_done = (m_done != 0 || dn) ? 1 : 0;
    p_fin  = (m_fin != 0 || (p_done != 0 && p_size == 0)) ? 1 : 0;
    if (psh) exp_q.push_back(v);
  endtask

  task automatic capture_word(input logic [15:0] v);
    step(1'b1, v, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    repeat (n) step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic reset_checks();
    check("rst_out_valid", 32'(sink_if.out_valid), 32'h0);
    check("rst_out_data", 32'(sink_if.out_data), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_last_value", 32'(last_value), 32'h0);
    check("rst_finished", 32'(finished), 32'h0);
    check("rst_digit_an", 32'(digit_an), 32'hE);
    check("rst_digit_hex", 32'(digit_hex), 32'h0);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    int idx;
    if (chk_en && rst_n) begin
      check("count", 32'(count), 32'(m_size));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("last_value", 32'(last_value), 32'(m_last));
      check("finished", 32'(finished), 32'(m_fin));
      check("out_valid", 32'(sink_if.out_valid), 32'(m_size != 0));
      if (m_size > 0) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underrun", 32'h1, 32'h0);
        end else begin
          check("out_data", 32'(sink_if.out_data), 32'(exp_q[0]));
          if (sink_if.out_ready) void'(exp_q.pop_front());
        end
      end
      idx = (edges / SCAN_DIV) % 4;
      check("digit_an", 32'(digit_an), 32'(4'hF ^ (4'h1 << idx)));
      check("digit_hex", 32'(digit_hex), 32'((m_last >> (4 * idx)) & 15));
    end
  end

  initial begin
    rst_n = 1'b0; da = 1'b0; value = '0; done = 1'b0; sink_if.out_ready = 1'b0;
    model_reset();
    #11;
    reset_checks();
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // single capture from a 3-cycle strobe
    repeat (3) step(1'b1, 16'h1234, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("single_count", 32'(count), 32'h1);
    check("single_valid", 32'(sink_if.out_valid), 32'h1);
    check("single_data", 32'(sink_if.out_data), 32'h1234);
    check("single_last", 32'(last_value), 32'h1234);
    repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0);
    check("single_once", 32'(count), 32'h1);
    drain(1);

    // fill and overflow
    for (int i = 1; i <= 5; i++) capture_word(16'(i));
    check("fill_count", 32'(count), 32'h4);
    check("fill_overflow", 32'(overflow), 32'h1);
    check("fill_last", 32'(last_value), 32'h5);
    check("fill_head", 32'(sink_if.out_data), 32'h1);
    drain(1);
    check("fill_after_pop", 32'(count), 32'h3);

    // asynchronous reset with 3 words queued and overflow set
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    chk_en = 1'b0;
    da = 1'b0; value = '0; done = 1'b0; sink_if.out_ready = 1'b0;
    #1;
    reset_checks();
    model_reset();
    #3;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // full FIFO with capture and pop on the same edge
    for (int i = 1; i <= 4; i++) capture_word(16'(i));
    check("full_count", 32'(count), 32'h4);
    step(1'b1, 16'h00AA, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("simpop_count", 32'(count), 32'h4);
    check("simpop_overflow", 32'(overflow), 32'h0);
    check("simpop_head", 32'(sink_if.out_data), 32'h2);
    drain(4);

    // finished only once done has been seen and the FIFO is empty
    capture_word(16'hBEEF);
    step(1'b0, 16'h0, 1'b0, 1'b1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("fin_before_pop", 32'(finished), 32'h0);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("fin_after_pop", 32'(finished), 32'h1);
    repeat (2) step(1'b0, 16'h0, 1'b0, 1'b0);

    // capture after finished, then watch the scan over several full rotations
    capture_word(16'hABCD);
    check("fin_sticky", 32'(finished), 32'h1);
    check("late_capture_count", 32'(count), 32'h1);
    repeat (36) step(1'b0, 16'h0, 1'b0, 1'b0);
    drain(1);

    // random traffic
    repeat (500) begin
      step(($urandom_range(0, 2) == 0), 16'($urandom), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 60) == 0));
    end
    drain(DEPTH + 1);
    check("end_empty", 32'(count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/display_sink.md
# display_sink

Receiving end of the processor's display interface. It detects each new `display_availiable` assertion, captures the 16-bit `value` into a small FIFO, and hands captured words downstream over a valid/ready port. It also scans the most recent value onto a 4-digit multiplexed hex display and flags when the processor is `done` and every captured word has been drained. It sits beside `processor` at the board top level.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries. Must be a power of 2 and at least 2.
- `SCAN_DIV`, default 1024: clock cycles per display digit slot. Must be at least 2.

Ports:
- `clk`, input, 1: the single clock. Everything is on its rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `display_availiable`, input, 1: processor display strobe. It is level and may stay high for several cycles.
- `value`, input, 16: processor display data. Valid while `display_availiable` is high.
- `done`, input, 1: processor done indication.
- `out_valid`, output, 1: the FIFO head is valid.
- `out_data`, output, 16: the FIFO head word.
- `out_ready`, input, 1: downstream accepts `out_data`.
- `count`, output, log2(DEPTH)+1: current FIFO occupancy.
- `overflow`, output, 1: sticky. Set when a capture is dropped because the FIFO is full.
- `last_value`, output, 16: most recently captured `value`.
- `digit_an`, output, 4: digit enables, active-low, one-hot-low.
- `digit_hex`, output, 4: the nibble for the enabled digit.
- `finished`, output, 1: sticky. `done` has been seen and the FIFO is empty.

## Operation
- **Edge detect.** Register `da_q` holds `display_availiable` from the previous cycle.
  - `capture = display_availiable & ~da_q`.
  - `da_q` resets to 0, so a high level at the first clock after reset counts as a capture.
- **Capture.**
  - On `capture`, `last_value` takes `value`. This happens whether the FIFO accepts the word or not.
  - The word is pushed if `count < DEPTH`, or if `count == DEPTH` and a pop occurs in the same cycle.
  - Otherwise the word is dropped and `overflow` goes to 1. `overflow` stays 1 until reset.
- **Pop.** `pop = out_valid & out_ready`.
  - `out_valid = (count != 0)`.
  - `out_data = mem[rd_ptr]`.
  - When `out_valid` is 0, `out_data` holds the last read location and has no meaning.
- **Pointers.**
  - `wr_ptr` and `rd_ptr` are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - `count` does the following:
    - +1 on push only.
    - -1 on pop only.
    - Unchanged on simultaneous push and pop.
  - When empty, push and pop cannot coincide, because `out_valid` is 0.
- **Done tracking.**
  - `done_seen` is set when `done` is 1 and stays set until reset.
  - `finished` is registered as `done_seen_next & (count_next == 0)`. Once set it stays set until reset.
  - A capture arriving after `finished` still goes into the FIFO. It does not clear `finished`.
- **Display scan.**
  - `scan_cnt` counts 0 to SCAN_DIV-1, then wraps.
  - `digit_idx` (2 bits) advances by 1 when `scan_cnt == SCAN_DIV-1`, wrapping 3 to 0.
  - `digit_an = ~(4'b0001 << digit_idx)`.
  - `digit_hex` is nibble `digit_idx` of `last_value` (idx 0 is bits 3:0).
- **Reset.** Asserting `rst_n` low at any time, including mid-transfer, immediately clears all state. FIFO contents are discarded.

## Timing
- **Reset values:**
  - `out_valid` 0, `out_data` 0 (memory cleared), `count` 0.
  - `overflow` 0, `last_value` 0, `finished` 0.
  - `digit_an` 4'b1110, `digit_hex` 0.
  - `da_q`, `done_seen`, both pointers, `scan_cnt` and `digit_idx` all 0.
- **Capture latency.** `capture` is true at edge t when `display_availiable` is sampled 1 at t and was sampled 0 at t-1. The word appears in `count`, `out_valid`/`out_data` and `last_value` after edge t.
- **Pop.** A pop is sampled at edge t and takes effect after edge t. The next word (or `out_valid` = 0) is visible in the following cycle.
- **Throughput.** One push and one pop per cycle. Holding `display_availiable` high produces exactly one capture.
- **Digit change.** `digit_hex` changes in the same cycle as `digit_an`, one cycle after `scan_cnt` reaches SCAN_DIV-1.

## Test plan
- **Single capture.** From reset, pulse `display_availiable` high for 3 cycles with `value`=16'h1234, `out_ready`=0. Required:
  - `count`=1, `out_valid`=1, `out_data`=16'h1234, `last_value`=16'h1234.
  - Exactly one capture.
- **Fill and overflow.** Do 5 separated captures (16'h0001 to 16'h0005) with `out_ready`=0 and DEPTH=4. Required:
  - `count`=4 and `overflow`=1.
  - `last_value`=16'h0005.
  - Draining yields 1, 2, 3, 4.
- **Full with simultaneous pop.** With the FIFO full (1 to 4), capture 16'h00AA in the same cycle as a pop. Required:
  - `count` stays 4 and `overflow` stays 0.
  - Drain order is 2, 3, 4, AA.
- **Finished.** Capture 16'hBEEF, then pulse `done` with `out_ready`=0. Required: `finished`=0. Then raise `out_ready`: `finished`=1 the cycle after the pop, and it stays 1 when `done` drops.
- **Scan.** With SCAN_DIV=4 and `last_value`=16'hABCD, the sequence is:
  - (1110, D), (1101, C), (1011, B), (0111, A), each lasting 4 cycles.
  - Then wrap back to (1110, D).
- **Reset mid-operation.** With 3 words queued and `overflow`=1, assert `rst_n`=0 asynchronously. Required: all outputs go immediately to the reset values listed under Timing.
